// File: rtl/vram_write_scheduler_pkg.sv
// Shared definitions for the VRAM write scheduler: geometry, widths, colours, FSM states.
package vram_write_scheduler_pkg;

  localparam int unsigned DefVramW = 80;
  localparam int unsigned DefVramH = 60;
  localparam int unsigned AddrW    = 13;
  localparam int unsigned ColorW   = 3;
  localparam int unsigned CoordW   = 8;

  typedef logic [AddrW-1:0]  addr_t;
  typedef logic [ColorW-1:0] color_t;
  typedef logic [CoordW-1:0] coord_t;

  // 3-bit RGB colour codes, bit 2 = red, bit 1 = green, bit 0 = blue.
  typedef enum logic [ColorW-1:0] {
    ColBlack, ColBlue, ColGreen, ColCyan, ColRed, ColMagenta, ColYellow, ColWhite
  } color_e;

  typedef enum logic [1:0] {StIdle, StSetup, StFill, StDone} fill_state_e;

  function automatic coord_t clamp_coord(coord_t v, coord_t lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/vram_write_scheduler_if.sv
// CPU pixel/fill request bus plus the registered VRAM write port.
interface vram_write_scheduler_if;
  import vram_write_scheduler_pkg::*;

  logic   pixel_we;
  coord_t pixel_x;
  coord_t pixel_y;
  color_t pixel_color;
  logic   fill_start;
  coord_t fill_x0;
  coord_t fill_y0;
  coord_t fill_x1;
  coord_t fill_y1;
  color_t fill_color;
  logic   fill_busy;
  logic   fill_done;
  logic   vram_we;
  addr_t  vram_addr;
  color_t vram_data;

  modport master (
    output pixel_we, pixel_x, pixel_y, pixel_color,
    output fill_start, fill_x0, fill_y0, fill_x1, fill_y1, fill_color,
    input  fill_busy, fill_done, vram_we, vram_addr, vram_data
  );

  modport slave (
    input  pixel_we, pixel_x, pixel_y, pixel_color,
    input  fill_start, fill_x0, fill_y0, fill_x1, fill_y1, fill_color,
    output fill_busy, fill_done, vram_we, vram_addr, vram_data
  );

endinterface

// File: rtl/vram_addr_calc.sv
// Combinational (x,y) to linear VRAM address: y*VramW + x.
module vram_addr_calc
  import vram_write_scheduler_pkg::*;
#(
  parameter int unsigned VramW = DefVramW
) (
  input  coord_t x_i,
  input  coord_t y_i,
  output addr_t  addr_o
);

  // The default 80-wide layout uses y*64 + y*16 so no multiplier is needed.
  always_comb begin
    if (VramW == 80) begin
      addr_o = (addr_t'(y_i) << 6) + (addr_t'(y_i) << 4) + addr_t'(x_i);
    end else begin
      addr_o = addr_t'(y_i) * addr_t'(VramW) + addr_t'(x_i);
    end
  end

endmodule

// File: rtl/vram_write_scheduler.sv
// Merges CPU single-pixel writes with a rectangle-fill engine onto one VRAM write port.
// CPU writes always win; the fill cursor stalls for that cycle.
module vram_write_scheduler
  import vram_write_scheduler_pkg::*;
#(
  parameter int unsigned VramW = DefVramW,
  parameter int unsigned VramH = DefVramH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  vram_write_scheduler_if.slave  bus
);

  localparam coord_t MaxX = coord_t'(VramW - 1);
  localparam coord_t MaxY = coord_t'(VramH - 1);

  fill_state_e state_q, state_d;
  coord_t x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  coord_t cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  color_t color_q, color_d;
  logic   vram_we_q, vram_we_d, fill_done_q, fill_done_d;
  addr_t  vram_addr_q, vram_addr_d;
  color_t vram_data_q, vram_data_d;

  addr_t cpu_addr, fill_addr;
  logic  cpu_valid, fill_fire, fill_last;

  vram_addr_calc #(.VramW(VramW)) u_cpu_addr (
    .x_i    (bus.pixel_x),
    .y_i    (bus.pixel_y),
    .addr_o (cpu_addr)
  );

  vram_addr_calc #(.VramW(VramW)) u_fill_addr (
    .x_i    (cur_x_q),
    .y_i    (cur_y_q),
    .addr_o (fill_addr)
  );

  assign cpu_valid = bus.pixel_we && (32'(bus.pixel_x) < VramW) && (32'(bus.pixel_y) < VramH);
  assign fill_fire = (state_q == StFill) && !cpu_valid;
  assign fill_last = (cur_x_q == x1_q) && (cur_y_q == y1_q);

  // Fill FSM next state, corner latching/clamping and raster cursor.
  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    color_d = color_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    unique case (state_q)
      StIdle: begin
        if (bus.fill_start) begin
          x0_d    = bus.fill_x0;
          y0_d    = bus.fill_y0;
          x1_d    = bus.fill_x1;
          y1_d    = bus.fill_y1;
          color_d = bus.fill_color;
          state_d = StSetup;
        end
      end
      StSetup: begin
        x1_d = clamp_coord(x1_q, MaxX);
        y1_d = clamp_coord(y1_q, MaxY);
        if ((x0_q > x1_d) || (y0_q > y1_d)) begin
          state_d = StDone;
        end else begin
          cur_x_d = x0_q;
          cur_y_d = y0_q;
          state_d = StFill;
        end
      end
      StFill: begin
        if (fill_fire) begin
          if (fill_last) begin
            state_d = StDone;
          end else if (cur_x_q == x1_q) begin
            cur_x_d = x0_q;
            cur_y_d = cur_y_q + 8'd1;
          end else begin
            cur_x_d = cur_x_q + 8'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Write-port mux; address and data hold when nothing is written.
  always_comb begin
    vram_we_d   = cpu_valid || fill_fire;
    vram_addr_d = vram_addr_q;
    vram_data_d = vram_data_q;
    if (cpu_valid) begin
      vram_addr_d = cpu_addr;
      vram_data_d = bus.pixel_color;
    end else if (fill_fire) begin
      vram_addr_d = fill_addr;
      vram_data_d = color_q;
    end
    fill_done_d = (state_q == StDone);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      x0_q        <= '0;
      y0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      color_q     <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      vram_we_q   <= 1'b0;
      vram_addr_q <= '0;
      vram_data_q <= '0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      color_q     <= color_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      vram_we_q   <= vram_we_d;
      vram_addr_q <= vram_addr_d;
      vram_data_q <= vram_data_d;
      fill_done_q <= fill_done_d;
    end
  end

  assign bus.fill_busy = (state_q != StIdle);
  assign bus.fill_done = fill_done_q;
  assign bus.vram_we   = vram_we_q;
  assign bus.vram_addr = vram_addr_q;
  assign bus.vram_data = vram_data_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed bench for vram_write_scheduler: CPU writes, fills, clamping, arbitration, reset abort.
module tb_vram_write_scheduler;
  import vram_write_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vram_write_scheduler_if bus ();

  vram_write_scheduler #(.VramW(80), .VramH(60)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   got_addr[$], got_data[$], exp_addr[$], exp_data[$];
  int   done_k, done_cnt, n_we;
  logic busy_first, busy_last;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pixel_we    = 1'b0;
    bus.pixel_x     = '0;
    bus.pixel_y     = '0;
    bus.pixel_color = '0;
    bus.fill_start  = 1'b0;
    bus.fill_x0     = '0;
    bus.fill_y0     = '0;
    bus.fill_x1     = '0;
    bus.fill_y1     = '0;
    bus.fill_color  = '0;
  endtask

  task automatic set_fill(input int x0, input int y0, input int x1, input int y1, input int col);
    bus.fill_start = 1'b1;
    bus.fill_x0    = 8'(x0);
    bus.fill_y0    = 8'(y0);
    bus.fill_x1    = 8'(x1);
    bus.fill_y1    = 8'(y1);
    bus.fill_color = 3'(col);
  endtask

  // k = 0 is the edge that accepts the start; every later edge is sampled 1 ns after it.
  task automatic fill_run(input int x0, input int y0, input int x1, input int y1, input int col,
                          input int cpu_at, input int cpu_x, input int cpu_y, input int cpu_col,
                          input bit ign_start, input int n_cyc);
    got_addr.delete();
    got_data.delete();
    done_k   = -1;
    done_cnt = 0;
    for (int k = 0; k < n_cyc; k++) begin
      idle_inputs();
      if (k == 0) set_fill(x0, y0, x1, y1, col);
      if (ign_start && (k == 1 || k == 2)) set_fill(0, 0, 0, 0, 5);
      if (k == cpu_at) begin
        bus.pixel_we    = 1'b1;
        bus.pixel_x     = 8'(cpu_x);
        bus.pixel_y     = 8'(cpu_y);
        bus.pixel_color = 3'(cpu_col);
      end
      tick();
      if (bus.vram_we) begin
        got_addr.push_back(int'(bus.vram_addr));
        got_data.push_back(int'(bus.vram_data));
      end
      if (bus.fill_done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (k == 1) busy_first = bus.fill_busy;
    end
    busy_last = bus.fill_busy;
    idle_inputs();
  endtask

  task automatic check_seq(input string tag);
    check_eq({tag, "_nwr"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < got_addr.size()) begin
        check_eq($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
        check_eq($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    check_eq("rst_we",   int'(bus.vram_we), 0);
    check_eq("rst_busy", int'(bus.fill_busy), 0);
    check_eq("rst_done", int'(bus.fill_done), 0);
    check_eq("rst_addr", int'(bus.vram_addr), 0);
    check_eq("rst_data", int'(bus.vram_data), int'(ColBlack));
    rst_n = 1'b1;
    tick();

    // Single CPU write, then hold behaviour and out-of-range drops.
    bus.pixel_we = 1'b1; bus.pixel_x = 8'd5; bus.pixel_y = 8'd2; bus.pixel_color = ColCyan;
    tick();
    check_eq("cpu_we",   int'(bus.vram_we), 1);
    check_eq("cpu_addr", int'(bus.vram_addr), 165);
    check_eq("cpu_data", int'(bus.vram_data), 3);
    idle_inputs();
    tick();
    check_eq("hold_we",   int'(bus.vram_we), 0);
    check_eq("hold_addr", int'(bus.vram_addr), 165);
    check_eq("hold_data", int'(bus.vram_data), 3);
    bus.pixel_we = 1'b1; bus.pixel_x = 8'd80; bus.pixel_y = 8'd0; bus.pixel_color = ColWhite;
    tick();
    check_eq("oob_x_we", int'(bus.vram_we), 0);
    bus.pixel_x = 8'd0; bus.pixel_y = 8'd60;
    tick();
    check_eq("oob_y_we", int'(bus.vram_we), 0);
    check_eq("oob_addr", int'(bus.vram_addr), 165);
    idle_inputs();
    tick();

    // Uncontested 3x2 fill.
    fill_run(10, 1, 12, 2, 7, -1, 0, 0, 0, 1'b0, 12);
    exp_addr = '{90, 91, 92, 170, 171, 172};
    exp_data = '{7, 7, 7, 7, 7, 7};
    check_seq("fill");
    check_eq("fill_done_k",   done_k, 8);
    check_eq("fill_done_cnt", done_cnt, 1);
    check_eq("fill_busy1",    int'(busy_first), 1);
    check_eq("fill_busy_end", int'(busy_last), 0);

    // Same fill with a CPU write stealing the slot of the second fill pixel.
    fill_run(10, 1, 12, 2, 7, 3, 0, 0, 0, 1'b0, 12);
    exp_addr = '{90, 0, 91, 92, 170, 171, 172};
    exp_data = '{7, 0, 7, 7, 7, 7, 7};
    check_seq("arb");
    check_eq("arb_done_k",   done_k, 9);
    check_eq("arb_done_cnt", done_cnt, 1);

    // CPU write in the same cycle as the fill start.
    fill_run(2, 0, 3, 0, 7, 0, 1, 1, 3, 1'b0, 8);
    exp_addr = '{81, 2, 3};
    exp_data = '{3, 7, 7};
    check_seq("co");
    check_eq("co_done_k", done_k, 4);

    // Fill clamped at the bottom-right corner.
    fill_run(78, 58, 200, 200, 6, -1, 0, 0, 0, 1'b0, 10);
    exp_addr = '{4718, 4719, 4798, 4799};
    exp_data = '{6, 6, 6, 6};
    check_seq("clamp");
    check_eq("clamp_done_k", done_k, 6);

    // Empty fill with a second start offered while busy.
    fill_run(20, 5, 10, 5, 2, -1, 0, 0, 0, 1'b1, 10);
    exp_addr.delete();
    exp_data.delete();
    check_seq("empty");
    check_eq("empty_done_k",   done_k, 2);
    check_eq("empty_done_cnt", done_cnt, 1);
    check_eq("empty_busy_end", int'(busy_last), 0);

    // Reset during the third pixel of a 4x4 fill.
    idle_inputs();
    set_fill(0, 0, 3, 3, 3);
    tick();
    idle_inputs();
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_eq("abort_we",   int'(bus.vram_we), 0);
    check_eq("abort_busy", int'(bus.fill_busy), 0);
    check_eq("abort_addr", int'(bus.vram_addr), 0);
    rst_n = 1'b1;
    done_cnt = 0;
    n_we     = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.fill_done) done_cnt++;
      if (bus.vram_we) n_we++;
    end
    check_eq("abort_no_done", done_cnt, 0);
    check_eq("abort_no_wr",   n_we, 0);

    fill_run(1, 1, 2, 1, 6, -1, 0, 0, 0, 1'b0, 8);
    exp_addr = '{81, 82};
    exp_data = '{6, 6};
    check_seq("after");
    check_eq("after_done_k", done_k, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vram_write_scheduler.md
VRAM_WRITE_SCHEDULER -- requirements
Module: vram_write_scheduler

Interface
REQ-001 Parameter VRAM_W, default 80, VRAM width in pixels.
REQ-002 Parameter VRAM_H, default 60, VRAM height in pixels.
REQ-003 Clock  input  1  single clock; all logic on rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset.
REQ-005 iPixelWe  input  1  CPU single-pixel write strobe (VGA instruction).
REQ-006 iPixelX / iPixelY  input  8 each  CPU pixel coordinates.
REQ-007 iPixelColor  input  3  CPU pixel colour.
REQ-008 iFillStart  input  1  rectangle-fill request, sampled only in IDLE.
REQ-009 iFillX0 / iFillY0 / iFillX1 / iFillY1  input  8 each  inclusive rectangle corners.
REQ-010 iFillColor  input  3  fill colour.
REQ-011 oFillBusy  output  1  high while a fill is in progress.
REQ-012 oFillDone  output  1  one-cycle completion pulse.
REQ-013 oVramWe / oVramAddr / oVramData  output  1 / 13 / 3  registered VRAM write port.

Function
REQ-014 Address SHALL be y*VRAM_W + x, computed as (y<<6)+(y<<4)+x for the default, 13-bit result.
REQ-015 CPU write: when iPixelWe=1 and x<VRAM_W and y<VRAM_H, the write SHALL appear on the port on the next cycle; out-of-range CPU writes are dropped silently.
REQ-016 FSM states are IDLE, SETUP, FILL and DONE.
REQ-017 IDLE: iFillStart=1 latches the corners and colour and moves to SETUP. Start SHALL be ignored in any other state.
REQ-018 SETUP: clamp x1 to VRAM_W-1 and y1 to VRAM_H-1. If x0>x1 or y0>y1 after clamping, go to DONE with zero writes; otherwise load the cursor to (x0,y0) and go to FILL.
REQ-019 FILL: emit one pixel per cycle in raster order, x inner and y outer; after (x1,y1) go to DONE.
REQ-020 The total fill write count SHALL equal (x1-x0+1)*(y1-y0+1) after clamping.
REQ-021 Arbitration: a valid CPU write always wins. The fill cursor SHALL hold that cycle and the pending fill pixel is emitted on the next free cycle; no pixel is lost or duplicated.
REQ-022 A CPU write coinciding with iFillStart SHALL be accepted; both are serviced.
REQ-023 DONE: oFillDone=1 for exactly one cycle, then IDLE.
REQ-024 oFillBusy=1 in SETUP, FILL and DONE; 0 in IDLE.
REQ-025 Latency: start accepted at edge t; first fill write valid at t+2 when uncontested; empty fill gives oFillDone at t+2.
REQ-026 oVramWe SHALL be 0 in any cycle with no CPU or fill write; oVramAddr and oVramData SHALL then hold their last value.

Reset
REQ-027 Reset=0 at a rising edge SHALL force IDLE and oVramWe=0, oFillBusy=0, oFillDone=0, oVramAddr=0, oVramData=0, from any state including mid-FILL.
REQ-028 An aborted fill SHALL NOT resume and SHALL produce no oFillDone.

Structure
REQ-029 VRAM_W, VRAM_H, address width (13), colour width (3) and colour codes SHALL live in the shared definitions include file.
REQ-030 Sub-module vram_addr_calc SHALL hold the combinational x,y-to-address mapping, instanced once for the CPU path and once for the fill path.
REQ-031 The target is 120-400 lines of RTL; no memories are inside the block.

Verification
REQ-032 CPU write x=5,y=2,colour=3 -> next cycle oVramWe=1, oVramAddr=165, oVramData=3.
REQ-033 Fill (10,1)-(12,2), colour 7, no CPU traffic -> addresses 90,91,92,170,171,172 on consecutive cycles starting at t+2; oFillDone pulse the cycle after 172; oFillBusy low after that.
REQ-034 Same fill with a CPU write (0,0) in the cycle the second fill pixel is due -> sequence 90,0,91,92,170,171,172; exactly six fill writes.
REQ-035 Fill (78,58)-(200,200) -> writes 4718,4719,4798,4799 only.
REQ-036 Fill (20,5)-(10,5) -> zero writes, oFillDone at t+2; a second iFillStart during busy is ignored.
REQ-037 Reset=0 during the third pixel of a 4x4 fill -> next cycle oVramWe=0, oFillBusy=0; no oFillDone afterwards; a subsequent fill runs normally.
